// File: rtl/pixel_readout_pkg.sv
// pixel_readout_pkg: shared types and constants for the pixel readout FIFO.
//   PIX_W, PIX_PER_WORD : pixel width and pixels packed per 32-bit databus word
//   fifo_entry_t        : buffered word plus its frame markers
//   ENTRY_W             : flat width of fifo_entry_t, used on FIFO ports
//   unpack_state_t      : unpacker FSM states
package pixel_readout_pkg;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned PIX_PER_WORD = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
  } fifo_entry_t;

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  typedef enum logic {
    IDLE,
    EMIT
  } unpack_state_t;

endpackage

// File: rtl/pixel_word_fifo.sv
// pixel_word_fifo: synchronous FIFO of fifo_entry_t words.
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   push, wdata     : write request and entry (ignored while full)
//   pop, rdata      : read request (ignored while empty) and head entry (show-ahead)
//   full, empty     : status from the current pointers
//   count           : number of stored entries
module pixel_word_fifo
  import pixel_readout_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry an extra wrap bit: equal indices with differing wrap bits means full.
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[PTR_W-1:0]] <= fifo_entry_t'(wdata);
  end

endmodule

// File: rtl/pixel_readout_fifo.sv
// pixel_readout_fifo: captures databus words during pixel READ, buffers them and
// unpacks each word into a handshaked 8-bit pixel stream with frame markers.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   bus_valid, databus  : input word strobe and four packed pixel codes (pixel 0 = [7:0])
//   frame_start         : pulse that restarts the word index of the frame
//   pix_valid/pix_ready : output handshake; pix_data, pix_sof, pix_eof describe the pixel
//   overflow            : sticky flag, a word arrived while the FIFO was full
//   frame_count         : frames whose last pixel has been transferred (wraps)
module pixel_readout_fifo
  import pixel_readout_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned WORDS_PER_FRAME = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_valid,
  input  logic [31:0] databus,
  input  logic        frame_start,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic        pix_sof,
  output logic        pix_eof,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int unsigned WIDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [1:0]        BIDX_LAST = 2'(PIX_PER_WORD - 1);

  // Word index within the frame
  logic [WIDX_W-1:0] widx_q;
  logic [WIDX_W-1:0] widx_d;
  logic [WIDX_W-1:0] widx_cur;

  // FIFO interface
  fifo_entry_t              push_entry;
  logic [ENTRY_W-1:0]       fifo_rdata;
  fifo_entry_t              fifo_head;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count;

  // Unpacker
  unpack_state_t state_q;
  unpack_state_t state_d;
  fifo_entry_t   hold_q;
  fifo_entry_t   hold_d;
  logic [1:0]    bidx_q;
  logic [1:0]    bidx_d;
  logic          xfer;

  logic          overflow_q;
  logic [15:0]   frame_count_q;

  // A word arriving with frame_start is always word 0 of the new frame.
  assign widx_cur = frame_start ? '0 : widx_q;

  always_comb begin
    widx_d = widx_q;
    if (bus_valid) begin
      // Advances even when the word is dropped so framing stays aligned.
      widx_d = (widx_cur == WIDX_LAST) ? '0 : widx_cur + 1'b1;
    end else if (frame_start) begin
      widx_d = '0;
    end
  end

  assign push_entry = {databus, (widx_cur == '0), (widx_cur == WIDX_LAST)};
  assign fifo_push  = bus_valid && !fifo_full;
  assign fifo_head  = fifo_entry_t'(fifo_rdata);

  pixel_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pix_valid = (state_q == EMIT);
  assign xfer      = pix_valid && pix_ready;
  assign pix_data  = pix_valid ? hold_q.data[{bidx_q, 3'b000} +: PIX_W] : '0;
  assign pix_sof   = pix_valid && hold_q.sof && (bidx_q == '0);
  assign pix_eof   = pix_valid && hold_q.eof && (bidx_q == BIDX_LAST);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    bidx_d   = bidx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_head;
          bidx_d   = '0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (pix_ready) begin
          if (bidx_q != BIDX_LAST) begin
            bidx_d = bidx_q + 1'b1;
          end else if (!fifo_empty) begin
            // Back-to-back words: reload on the same edge, no bubble.
            fifo_pop = 1'b1;
            hold_d   = fifo_head;
            bidx_d   = '0;
          end else begin
            hold_d  = '0;
            bidx_d  = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      bidx_q        <= '0;
      widx_q        <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      bidx_q  <= bidx_d;
      widx_q  <= widx_d;
      if (bus_valid && fifo_full) overflow_q <= 1'b1;
      if (xfer && pix_eof) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule
